// File: rtl/sw_hw_handshake_pkg.sv
// sw_hw_pkg: shared FSM state type, software command codes and status codes for the SW/HW mailbox.
//   Software headers mirror the CMD_* and ST_* values below.
package sw_hw_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_W_ACK,
        S_START,
        S_BUSY,
        S_R_RDY,
        S_R_ACK,
        S_DONE
    } state_t;
    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_RACK  = 2'b10;
    localparam logic [1:0] CMD_ABORT = 2'b11;
    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_W_ACK = 4'd1;
    localparam logic [3:0] ST_START = 4'd2;
    localparam logic [3:0] ST_BUSY  = 4'd2;
    localparam logic [3:0] ST_R_RDY = 4'd3;
    localparam logic [3:0] ST_R_ACK = 4'd4;
    localparam logic [3:0] ST_DONE  = 4'd5;
    // START and BUSY deliberately share a code: software only sees "engine running".
    function automatic logic [3:0] status_of(state_t s);
        return s == S_W_ACK ? ST_W_ACK :
               s == S_START ? ST_START :
               s == S_BUSY  ? ST_BUSY  :
               s == S_R_RDY ? ST_R_RDY :
               s == S_R_ACK ? ST_R_ACK :
               s == S_DONE  ? ST_DONE  : ST_IDLE;
    endfunction
endpackage

// File: rtl/sw_hw_handshake_if.sv
// sw_hw_handshake_if: PIO-side mailbox signals between the Nios II software and the handshake block.
//   from_sw_sig  (2)  software command: NONE/WRITE/READ_ACK/ABORT
//   from_sw_port (32) software write data
//   to_sw_sig    (4)  status code read by software
//   to_sw_port   (32) result word presented to software
//   master = software/PIO side, slave = hardware handshake side
interface sw_hw_handshake_if;
    logic [1:0]  from_sw_sig;
    logic [31:0] from_sw_port;
    logic [3:0]  to_sw_sig;
    logic [31:0] to_sw_port;
    modport master (output from_sw_sig, from_sw_port, input to_sw_sig, to_sw_port);
    modport slave  (input from_sw_sig, from_sw_port, output to_sw_sig, to_sw_port);
endinterface

// File: rtl/sw_hw_handshake.sv
// sw_hw_handshake: four-phase mailbox that assembles an operand from 32-bit words, starts the engine, and returns the result word by word.
//   clk, reset_n      clock and asynchronous active-low reset
//   sw (slave)        software command/data in, status/result word out
//   op_data  (W)      assembled operand, word 0 in [31:0]
//   op_start (1)      one-cycle engine start pulse
//   op_done  (1)      engine completion pulse, result valid in the same cycle
//   result   (W)      engine result, word 0 in [31:0]
module sw_hw_handshake
    import sw_hw_pkg::*;
#(
    parameter int WORDS = 4,
    parameter int W     = 32 * WORDS
) (
    input  logic                clk,
    input  logic                reset_n,
    sw_hw_handshake_if.slave    sw,
    output logic [W-1:0]        op_data,
    output logic                op_start,
    input  logic                op_done,
    input  logic [W-1:0]        result
);
    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
    localparam logic [IW-1:0] ONE  = IW'(1);
    state_t                  state, state_d;
    logic [IW-1:0]           idx, idx_d;
    logic [1:0]              sig_q;
    logic [31:0]             dat_q;
    logic [WORDS-1:0][31:0]  opbuf, resbuf;
    logic                    op_wr, res_wr;
    // Command inputs come from another PIO; everything acts on the registered copy only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sig_q  <= CMD_NONE;
            dat_q  <= '0;
            state  <= S_IDLE;
            idx    <= '0;
            opbuf  <= '0;
            resbuf <= '0;
        end else begin
            sig_q <= sw.from_sw_sig;
            dat_q <= sw.from_sw_port;
            state <= state_d;
            idx   <= idx_d;
            if (op_wr) opbuf[idx] <= dat_q;
            if (res_wr) resbuf <= result;
        end
    end
    always_comb begin
        state_d = state;
        idx_d   = idx;
        op_wr   = 1'b0;
        res_wr  = 1'b0;
        // ABORT wins over everything, including a coincident op_done.
        if (sig_q == CMD_ABORT) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (sig_q == CMD_WRITE) begin
                    op_wr   = 1'b1;
                    state_d = S_W_ACK;
                end
                S_W_ACK: if (sig_q == CMD_NONE) begin
                    idx_d   = idx == LAST ? '0 : idx + ONE;
                    state_d = idx == LAST ? S_START : S_IDLE;
                end
                S_START: state_d = S_BUSY;
                S_BUSY: if (op_done) begin
                    res_wr  = 1'b1;
                    idx_d   = '0;
                    state_d = S_R_RDY;
                end
                S_R_RDY: if (sig_q == CMD_RACK) state_d = S_R_ACK;
                // idx returns to 0 on entry to DONE so DONE can accept word 0 like IDLE.
                S_R_ACK: if (sig_q == CMD_NONE) begin
                    idx_d   = idx == LAST ? '0 : idx + ONE;
                    state_d = idx == LAST ? S_DONE : S_R_RDY;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end
    assign op_start      = state == S_START && sig_q != CMD_ABORT;
    assign op_data       = opbuf;
    assign sw.to_sw_sig  = status_of(state);
    assign sw.to_sw_port = (state == S_R_RDY || state == S_R_ACK) ? resbuf[idx] : '0;
endmodule

// File: tb/tb_sw_hw_handshake.sv
// tb_sw_hw_handshake: directed + randomized mailbox transfers checked against a word-level model of the protocol.
module tb_sw_hw_handshake;
    import sw_hw_pkg::*;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         op_start;
    logic         op_done = 1'b0;
    logic [127:0] op_data;
    logic [127:0] result = '0;
    int           errors = 0;
    int           checks = 0;
    int           starts = 0;
    logic [31:0]  exp_op [4];
    logic [127:0] exp_res;
    sw_hw_handshake_if sw();
    sw_hw_handshake #(.WORDS(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sw       (sw),
        .op_data  (op_data),
        .op_start (op_start),
        .op_done  (op_done),
        .result   (result)
    );
    always #5 clk = ~clk;
    always @(posedge clk) if (op_start) starts++;
    function automatic logic [127:0] op_model();
        return {exp_op[3], exp_op[2], exp_op[1], exp_op[0]};
    endfunction
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    // Drive a command at a falling edge; status is visible two edges later.
    task automatic cmd(input logic [1:0] c, input logic [31:0] d);
        sw.from_sw_sig  = c;
        sw.from_sw_port = d;
        cyc(2);
    endtask
    task automatic write_word(input int k, input logic [31:0] d);
        cmd(CMD_WRITE, d);
        chk("w_ack", sw.to_sw_sig, ST_W_ACK);
        exp_op[k] = d;
        cmd(CMD_NONE, 32'h0);
        chk("w_ret", sw.to_sw_sig, k == 3 ? ST_START : ST_IDLE);
        if (k == 3) chk("start_hi", op_start, 1'b1);
    endtask
    task automatic finish_write(input int s0);
        chk("op_data", op_data, op_model());
        cyc(1);
        chk("busy", sw.to_sw_sig, ST_BUSY);
        chk("start_lo", op_start, 1'b0);
        chk("start_cnt", starts, s0 + 1);
    endtask
    task automatic write_all(input logic [127:0] ws);
        int s0;
        s0 = starts;
        for (int k = 0; k < 4; k++) write_word(k, ws[k*32 +: 32]);
        finish_write(s0);
    endtask
    task automatic read_all(input logic [127:0] res);
        op_done = 1'b1;
        result  = res;
        cyc(1);
        op_done = 1'b0;
        exp_res = res;
        chk("r_rdy", sw.to_sw_sig, ST_R_RDY);
        chk("r_word0", sw.to_sw_port, res[31:0]);
        for (int k = 0; k < 4; k++) begin
            cmd(CMD_RACK, 32'h0);
            chk("r_ack", sw.to_sw_sig, ST_R_ACK);
            chk("r_ack_word", sw.to_sw_port, res[k*32 +: 32]);
            cmd(CMD_NONE, 32'h0);
            chk("r_next", sw.to_sw_sig, k == 3 ? ST_DONE : ST_R_RDY);
            chk("r_next_word", sw.to_sw_port, k == 3 ? 32'h0 : res[(k+1)*32 +: 32]);
        end
    endtask
    initial begin
        int s0;
        logic [31:0] d0;
        sw.from_sw_sig  = CMD_NONE;
        sw.from_sw_port = '0;
        for (int k = 0; k < 4; k++) exp_op[k] = '0;
        exp_res = '0;
        cyc(3);
        chk("rst_sig", sw.to_sw_sig, ST_IDLE);
        chk("rst_port", sw.to_sw_port, 32'h0);
        chk("rst_start", op_start, 1'b0);
        chk("rst_data", op_data, 128'h0);
        reset_n = 1'b1;
        cyc(2);
        write_all(128'h44444444_33333333_22222222_11111111);
        chk("op_data_fixed", op_data, 128'h44444444_33333333_22222222_11111111);
        read_all(128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        repeat (3) begin
            write_all({$urandom, $urandom, $urandom, $urandom});
            read_all({$urandom, $urandom, $urandom, $urandom});
        end
        write_word(0, $urandom);
        write_word(1, $urandom);
        cmd(CMD_ABORT, 32'h0);
        chk("abort_sig", sw.to_sw_sig, ST_IDLE);
        chk("abort_port", sw.to_sw_port, 32'h0);
        chk("abort_data", op_data, op_model());
        cmd(CMD_NONE, 32'h0);
        write_all({$urandom, $urandom, $urandom, $urandom});
        read_all({$urandom, $urandom, $urandom, $urandom});
        s0 = starts;
        d0 = $urandom;
        sw.from_sw_sig  = CMD_WRITE;
        sw.from_sw_port = d0;
        repeat (20) begin
            cyc(1);
            sw.from_sw_port = $urandom;
        end
        exp_op[0] = d0;
        chk("held_sig", sw.to_sw_sig, ST_W_ACK);
        chk("held_data", op_data, op_model());
        cmd(CMD_NONE, 32'h0);
        chk("held_ret", sw.to_sw_sig, ST_IDLE);
        cmd(CMD_RACK, 32'h0);
        chk("rack_idle_sig", sw.to_sw_sig, ST_IDLE);
        chk("rack_idle_port", sw.to_sw_port, 32'h0);
        cmd(CMD_NONE, 32'h0);
        for (int k = 1; k < 4; k++) write_word(k, $urandom);
        finish_write(s0);
        sw.from_sw_sig = CMD_ABORT;
        cyc(1);
        op_done = 1'b1;
        result  = {$urandom, $urandom, $urandom, $urandom};
        cyc(1);
        op_done = 1'b0;
        chk("abort_done_sig", sw.to_sw_sig, ST_IDLE);
        chk("abort_done_res", dut.resbuf, exp_res);
        sw.from_sw_sig = CMD_NONE;
        cyc(2);
        chk("abort_done_hold", sw.to_sw_sig, ST_IDLE);
        write_all({$urandom, $urandom, $urandom, $urandom});
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy_sig", sw.to_sw_sig, ST_IDLE);
        chk("rst_busy_port", sw.to_sw_port, 32'h0);
        chk("rst_busy_start", op_start, 1'b0);
        chk("rst_busy_data", op_data, 128'h0);
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
